// File: rtl/kernel_pkg.sv
// Shared constants and types for the GEMM operand feeder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package kernel_pkg;

    localparam int VECTOR_LENGTH   = 16;
    localparam int DATA_WIDTH      = 32;
    localparam int FEED_DIM_WIDTH  = 8;
    localparam int FEED_ADDR_WIDTH = 12;
    localparam int TILE_WIDTH      = VECTOR_LENGTH * DATA_WIDTH;

    typedef enum logic [1:0] {
        FD_IDLE,
        FD_RUN,
        FD_DRAIN,
        FD_DONE
    } feeder_state_e;

    // A job with any zero dimension has no tiles to issue.
    function automatic logic cfg_is_empty(
        input logic [FEED_DIM_WIDTH-1:0] m,
        input logic [FEED_DIM_WIDTH-1:0] n,
        input logic [FEED_DIM_WIDTH-1:0] kt
    );
        return (m == '0) || (n == '0) || (kt == '0);
    endfunction

endpackage

// File: rtl/feed_loop_counter.sv
// Three-level nested tile counter: k innermost, then n, then m, with wrap and last flags.
// Latency: flags are combinational from the current count; count advances one step per cycle.
// Backpressure: none; advances whenever step is high.
module feed_loop_counter
    import kernel_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      step,
    input  logic [FEED_DIM_WIDTH-1:0] cfg_m,
    input  logic [FEED_DIM_WIDTH-1:0] cfg_n,
    input  logic [FEED_DIM_WIDTH-1:0] cfg_kt,
    output logic [FEED_DIM_WIDTH-1:0] k,
    output logic                      k_wrap,
    output logic                      n_wrap,
    output logic                      last
);

    localparam logic [FEED_DIM_WIDTH-1:0] ONE = FEED_DIM_WIDTH'(1);

    logic [FEED_DIM_WIDTH-1:0] k_q, k_d;
    logic [FEED_DIM_WIDTH-1:0] n_q, n_d;
    logic [FEED_DIM_WIDTH-1:0] m_q, m_d;

    // Wrap flags and next count; a full wrap of all three levels returns to zero.
    always_comb begin
        k_wrap = (k_q == cfg_kt - ONE);
        n_wrap = k_wrap && (n_q == cfg_n - ONE);
        last   = n_wrap && (m_q == cfg_m - ONE);
        k_d    = k_q;
        n_d    = n_q;
        m_d    = m_q;
        if (clear) begin
            k_d = '0;
            n_d = '0;
            m_d = '0;
        end else if (step) begin
            if (k_wrap) begin
                k_d = '0;
                if (n_wrap) begin
                    n_d = '0;
                    m_d = last ? '0 : m_q + ONE;
                end else begin
                    n_d = n_q + ONE;
                end
            end else begin
                k_d = k_q + ONE;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            k_q <= '0;
            n_q <= '0;
            m_q <= '0;
        end else begin
            k_q <= k_d;
            n_q <= n_d;
            m_q <= m_d;
        end
    end

    assign k = k_q;

endmodule

// File: rtl/gemm_vector_feeder.sv
// Sequences A-row / B-column tile reads for C = A*B and forwards SRAM data to the adder-tree.
// Latency: first valid 2 cycles after start, done M*N*KT+2 cycles after start.
// Backpressure: none; the adder-tree takes one operand pair every cycle.
module gemm_vector_feeder
    import kernel_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [FEED_DIM_WIDTH-1:0]  cfg_m,
    input  logic [FEED_DIM_WIDTH-1:0]  cfg_n,
    input  logic [FEED_DIM_WIDTH-1:0]  cfg_kt,
    output logic                       busy,
    output logic                       done,
    output logic                       i_rd_en,
    output logic [FEED_ADDR_WIDTH-1:0] i_rd_addr,
    input  logic [TILE_WIDTH-1:0]      i_rd_data,
    output logic                       w_rd_en,
    output logic [FEED_ADDR_WIDTH-1:0] w_rd_addr,
    input  logic [TILE_WIDTH-1:0]      w_rd_data,
    output logic [TILE_WIDTH-1:0]      at_i_data,
    output logic [VECTOR_LENGTH-1:0]   at_i_valid,
    output logic [TILE_WIDTH-1:0]      at_w_data,
    output logic [VECTOR_LENGTH-1:0]   at_w_valid,
    output logic                       at_accum
);

    feeder_state_e             state_q, state_d;
    logic [FEED_DIM_WIDTH-1:0] m_cfg_q, m_cfg_d;
    logic [FEED_DIM_WIDTH-1:0] n_cfg_q, n_cfg_d;
    logic [FEED_DIM_WIDTH-1:0] kt_cfg_q, kt_cfg_d;
    logic [FEED_ADDR_WIDTH-1:0] i_base_q, i_base_d;
    logic [FEED_ADDR_WIDTH-1:0] w_base_q, w_base_d;
    logic issue_d1_q, issue_d1_d;
    logic accum_d1_q, accum_d1_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic                       issue;
    logic                       cnt_clear;
    logic [FEED_DIM_WIDTH-1:0]  k;
    logic                       k_wrap;
    logic                       n_wrap;
    logic                       last;
    logic [FEED_ADDR_WIDTH-1:0] kt_ext;

    assign kt_ext = FEED_ADDR_WIDTH'(kt_cfg_q);

    feed_loop_counter u_loop (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .step   (issue),
        .cfg_m  (m_cfg_q),
        .cfg_n  (n_cfg_q),
        .cfg_kt (kt_cfg_q),
        .k      (k),
        .k_wrap (k_wrap),
        .n_wrap (n_wrap),
        .last   (last)
    );

    // Next-state, base-address stepping and issue pipeline.
    always_comb begin
        state_d   = state_q;
        m_cfg_d   = m_cfg_q;
        n_cfg_d   = n_cfg_q;
        kt_cfg_d  = kt_cfg_q;
        i_base_d  = i_base_q;
        w_base_d  = w_base_q;
        cnt_clear = 1'b0;
        issue     = 1'b0;
        case (state_q)
            FD_IDLE: begin
                if (start) begin
                    m_cfg_d   = cfg_m;
                    n_cfg_d   = cfg_n;
                    kt_cfg_d  = cfg_kt;
                    i_base_d  = '0;
                    w_base_d  = '0;
                    cnt_clear = 1'b1;
                    // An empty job still passes through the drain cycle so that
                    // done lands at the uniform M*N*KT+2 offset (here, 2).
                    state_d   = cfg_is_empty(cfg_m, cfg_n, cfg_kt) ? FD_DRAIN : FD_RUN;
                end
            end
            FD_RUN: begin
                issue = 1'b1;
                if (k_wrap) begin
                    if (n_wrap) begin
                        w_base_d = '0;
                        i_base_d = i_base_q + kt_ext;
                    end else begin
                        w_base_d = w_base_q + kt_ext;
                    end
                end
                if (last) begin
                    state_d = FD_DRAIN;
                end
            end
            FD_DRAIN: state_d = FD_DONE;
            FD_DONE:  state_d = FD_IDLE;
            default:  state_d = FD_IDLE;
        endcase
        issue_d1_d = issue;
        accum_d1_d = issue && (k != '0);
        busy_d     = (state_d == FD_RUN) || (state_d == FD_DRAIN);
        done_d     = (state_d == FD_DONE);
    end

    // FSM state, latched job, base addresses and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FD_IDLE;
            m_cfg_q    <= '0;
            n_cfg_q    <= '0;
            kt_cfg_q   <= '0;
            i_base_q   <= '0;
            w_base_q   <= '0;
            issue_d1_q <= 1'b0;
            accum_d1_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_cfg_q    <= m_cfg_d;
            n_cfg_q    <= n_cfg_d;
            kt_cfg_q   <= kt_cfg_d;
            i_base_q   <= i_base_d;
            w_base_q   <= w_base_d;
            issue_d1_q <= issue_d1_d;
            accum_d1_q <= accum_d1_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign i_rd_en    = issue;
    assign w_rd_en    = issue;
    assign i_rd_addr  = issue ? i_base_q + FEED_ADDR_WIDTH'(k) : '0;
    assign w_rd_addr  = issue ? w_base_q + FEED_ADDR_WIDTH'(k) : '0;
    // Data is forwarded straight from the SRAMs, zeroed outside valid cycles.
    assign at_i_data  = issue_d1_q ? i_rd_data : '0;
    assign at_w_data  = issue_d1_q ? w_rd_data : '0;
    assign at_i_valid = {VECTOR_LENGTH{issue_d1_q}};
    assign at_w_valid = {VECTOR_LENGTH{issue_d1_q}};
    assign at_accum   = accum_d1_q;

endmodule

// File: tb/tb_gemm_vector_feeder.sv
module tb_gemm_vector_feeder;
    import kernel_pkg::*;

    localparam int TW = TILE_WIDTH;
    localparam int AW = FEED_ADDR_WIDTH;
    localparam int DW = FEED_DIM_WIDTH;
    localparam int VL = VECTOR_LENGTH;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] cfg_m, cfg_n, cfg_kt;
    logic          busy, done;
    logic          i_rd_en, w_rd_en;
    logic [AW-1:0] i_rd_addr, w_rd_addr;
    logic [TW-1:0] i_rd_data, w_rd_data;
    logic [TW-1:0] at_i_data, at_w_data;
    logic [VL-1:0] at_i_valid, at_w_valid;
    logic          at_accum;

    always #5 clk = ~clk;

    gemm_vector_feeder dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cfg_m      (cfg_m),
        .cfg_n      (cfg_n),
        .cfg_kt     (cfg_kt),
        .busy       (busy),
        .done       (done),
        .i_rd_en    (i_rd_en),
        .i_rd_addr  (i_rd_addr),
        .i_rd_data  (i_rd_data),
        .w_rd_en    (w_rd_en),
        .w_rd_addr  (w_rd_addr),
        .w_rd_data  (w_rd_data),
        .at_i_data  (at_i_data),
        .at_i_valid (at_i_valid),
        .at_w_data  (at_w_data),
        .at_w_valid (at_w_valid),
        .at_accum   (at_accum)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // SRAM contents and one-cycle read latency.
    logic [TW-1:0] i_mem [256];
    logic [TW-1:0] w_mem [256];

    always @(posedge clk) begin
        if (i_rd_en) i_rd_data <= i_mem[i_rd_addr[7:0]];
        if (w_rd_en) w_rd_data <= w_mem[w_rd_addr[7:0]];
    end

    task automatic fill_mem();
        for (int a = 0; a < 256; a++) begin
            for (int l = 0; l < VL; l++) begin
                i_mem[a][l*DATA_WIDTH +: DATA_WIDTH] = $urandom;
                w_mem[a][l*DATA_WIDTH +: DATA_WIDTH] = $urandom;
            end
        end
    endtask

    function automatic logic [31:0] dot(input logic [TW-1:0] a, input logic [TW-1:0] b);
        logic [31:0] s;
        s = 0;
        for (int l = 0; l < VL; l++) s += a[l*DATA_WIDTH +: DATA_WIDTH] * b[l*DATA_WIDTH +: DATA_WIDTH];
        return s;
    endfunction

    function automatic logic [31:0] golden(input int m, input int n, input int kt);
        logic [31:0] s;
        s = 0;
        for (int k = 0; k < kt; k++) s += dot(i_mem[m*kt+k], w_mem[n*kt+k]);
        return s;
    endfunction

    // Expected read stream and operand stream of a job.
    typedef struct { logic [AW-1:0] ia; logic [AW-1:0] wa; } rd_t;
    typedef struct { logic [TW-1:0] idat; logic [TW-1:0] wdat; logic accum; logic last_k; logic [31:0] c; } out_t;
    rd_t  rd_q[$];
    out_t out_q[$];

    task automatic build_model(input int m, input int n, input int kt);
        rd_q.delete();
        out_q.delete();
        for (int mi = 0; mi < m; mi++)
            for (int ni = 0; ni < n; ni++)
                for (int k = 0; k < kt; k++) begin
                    rd_t  r;
                    out_t o;
                    r.ia     = AW'(mi*kt + k);
                    r.wa     = AW'(ni*kt + k);
                    o.idat   = i_mem[mi*kt + k];
                    o.wdat   = w_mem[ni*kt + k];
                    o.accum  = (k != 0);
                    o.last_k = (k == kt - 1);
                    o.c      = golden(mi, ni, kt);
                    rd_q.push_back(r);
                    out_q.push_back(o);
                end
    endtask

    // Per-cycle comparison of reads and operands against the model.
    logic [31:0] acc = 0;
    always @(negedge clk) begin
        rd_t         r;
        out_t        o;
        logic [31:0] acc_n;
        if (i_rd_en || w_rd_en) begin
            check("rd_en_pair", {i_rd_en, w_rd_en}, 2'b11);
            check("rd_expected", rd_q.size() != 0, 1);
            if (rd_q.size() != 0) begin
                r = rd_q.pop_front();
                check("rd_addr", {i_rd_addr, w_rd_addr}, {r.ia, r.wa});
            end
        end
        if (at_i_valid != 0 || at_w_valid != 0) begin
            check("valid_all_ones", {at_i_valid, at_w_valid}, {2*VL{1'b1}});
            check("out_expected", out_q.size() != 0, 1);
            if (out_q.size() != 0) begin
                o = out_q.pop_front();
                check("at_i_data", at_i_data, o.idat);
                check("at_w_data", at_w_data, o.wdat);
                check("at_accum", at_accum, o.accum);
                acc_n = (at_accum ? acc : 32'd0) + dot(at_i_data, at_w_data);
                acc = acc_n;
                if (o.last_k) check("c_mn", acc_n, o.c);
            end
        end
    end

    // Runs one job, optionally with a second start at offset dup_at or a reset at offset rst_at.
    task automatic run_job(input int m, input int n, input int kt, input int dup_at, input int rst_at, input string tag);
        int   total;
        int   first_v, last_v, vcnt, done_off, done_cnt;
        logic busy1;
        total = m*n*kt;
        first_v = -1; last_v = -1; vcnt = 0; done_off = -1; done_cnt = 0; busy1 = 1'b0;
        build_model(m, n, kt);
        @(negedge clk);
        cfg_m = DW'(m); cfg_n = DW'(n); cfg_kt = DW'(kt); start = 1'b1;
        for (int i = 1; i <= total + 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                cfg_m = 8'd7; cfg_n = 8'd7; cfg_kt = 8'd7;
                busy1 = busy;
            end
            if (dup_at != 0 && i == dup_at) begin
                start = 1'b1; cfg_m = 8'd3; cfg_n = 8'd3; cfg_kt = 8'd3;
            end
            if (dup_at != 0 && i == dup_at + 1) start = 1'b0;
            if (rst_at != 0) begin
                if (i == rst_at) reset = 1'b1;
                if (i == rst_at + 1) begin
                    reset = 1'b0;
                    check({tag, "_post_reset_ctl"},
                          {busy, done, i_rd_en, w_rd_en, i_rd_addr, w_rd_addr, at_i_valid, at_w_valid, at_accum}, '0);
                    check({tag, "_post_reset_data"}, at_i_data | at_w_data, '0);
                end
                if (i > rst_at + 1 && done) done_cnt++;
                if (i == rst_at + 5) break;
            end else begin
                if (at_i_valid[0]) begin
                    vcnt++;
                    if (first_v < 0) first_v = i;
                    last_v = i;
                end
                if (done) begin
                    done_cnt++;
                    if (done_off < 0) begin
                        done_off = i;
                        check({tag, "_busy_at_done"}, busy, 0);
                    end
                end
                if (done_off >= 0 && i >= done_off + 3) break;
            end
        end
        if (rst_at != 0) begin
            check({tag, "_no_done_after_reset"}, done_cnt, 0);
            rd_q.delete();
            out_q.delete();
        end else begin
            check({tag, "_busy_after_start"}, busy1, 1);
            check({tag, "_valid_count"}, vcnt, total);
            check({tag, "_done_count"}, done_cnt, 1);
            check({tag, "_done_offset"}, done_off, total + 2);
            if (total > 0) begin
                check({tag, "_first_valid"}, first_v, 2);
                check({tag, "_no_bubbles"}, last_v - first_v + 1, total);
            end
            check({tag, "_reads_left"}, rd_q.size(), 0);
            check({tag, "_outs_left"}, out_q.size(), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int lit_i[12];
        int lit_w[12];
        int lit_a[12];
        lit_i = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
        lit_w = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
        lit_a = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};

        fill_mem();
        reset = 1'b1; start = 1'b0; cfg_m = '0; cfg_n = '0; cfg_kt = '0;
        repeat (2) @(negedge clk);
        check("reset_ctl", {busy, done, i_rd_en, w_rd_en, i_rd_addr, w_rd_addr, at_i_valid, at_w_valid, at_accum}, '0);
        check("reset_data", at_i_data | at_w_data, '0);
        reset = 1'b0;
        @(negedge clk);

        // 1x1x1: single tile, reads at 0/0, accum 0, done at offset 3.
        build_model(1, 1, 1);
        check("t1_model_addr", {rd_q[0].ia, rd_q[0].wa}, 0);
        check("t1_model_accum", out_q[0].accum, 0);
        run_job(1, 1, 1, 0, 0, "t1");

        // 2x2x3: address walk and accum pattern pinned to literals.
        build_model(2, 2, 3);
        for (int j = 0; j < 12; j++) begin
            check("t2_model_iaddr", rd_q[j].ia, lit_i[j]);
            check("t2_model_waddr", rd_q[j].wa, lit_w[j]);
            check("t2_model_accum", out_q[j].accum, lit_a[j]);
        end
        run_job(2, 2, 3, 0, 0, "t2");

        // Empty jobs: no reads, no valids, done at offset 2.
        run_job(2, 2, 0, 0, 0, "t3_kt0");
        run_job(0, 3, 2, 0, 0, "t3_m0");
        run_job(3, 0, 2, 0, 0, "t3_n0");

        // Second start mid-run and in the done cycle are both ignored.
        run_job(2, 2, 2, 3, 0, "t4_dup_run");
        run_job(2, 2, 2, 10, 0, "t4_dup_done");

        // KT=1 keeps accum low on every tile.
        run_job(3, 2, 1, 0, 0, "t_kt1");

        // Reset on the third issue cycle, then a clean rerun.
        run_job(2, 2, 2, 0, 3, "t5_reset");
        run_job(2, 2, 2, 0, 0, "t5_rerun");

        // Random shapes and data with end-to-end dot-product scoreboard.
        for (int r = 0; r < 4; r++) begin
            int rm, rn, rk;
            fill_mem();
            rm = $urandom_range(1, 4);
            rn = $urandom_range(1, 4);
            rk = $urandom_range(1, 4);
            run_job(rm, rn, rk, 0, 0, "t6_rand");
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
